// File: rtl/shot_resolver.sv
// shot_resolver: upstream stage of the battleship boats-left counter.
//   Holds the live ROWS x COLS ship board, accepts one shot per handshake, classifies it as
//   miss/hit/repeat/invalid, clears hit cells and tracks game end.
//   Optional feature macro: SHOT_LIMIT_EN (enforce a MAX_SHOTS budget per game).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_valid, board_in     load a new ship map (only in IDLE/DONE); bit r*COLS+c = cell (r,c)
//   shot_valid, shot_ready   shot handshake; ready only while armed
//   shot_row, shot_col       target coordinate
//   result_valid             one-cycle pulse qualifying result_code
//   result_code              00 miss, 01 hit, 10 repeat, 11 invalid
//   board_out                live ship cells, same bit mapping as board_in
//   shots_left               remaining budget (0 when the budget feature is off)
//   game_over, player_won    end-of-game flags, valid while in DONE
module shot_resolver #(
  parameter int unsigned ROWS      = 5,
  parameter int unsigned COLS      = 5,
  parameter int unsigned MAX_SHOTS = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [ROWS*COLS-1:0] board_in,
  input  logic                 shot_valid,
  output logic                 shot_ready,
  input  logic [2:0]           shot_row,
  input  logic [2:0]           shot_col,
  output logic                 result_valid,
  output logic [1:0]           result_code,
  output logic [ROWS*COLS-1:0] board_out,
  output logic [4:0]           shots_left,
  output logic                 game_over,
  output logic                 player_won
);

  localparam int unsigned NCells = ROWS * COLS;

`ifdef SHOT_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StArmed, StResolve, StReport, StDone} state_e;

  state_e              state;
  logic [2:0]          row_q;
  logic [2:0]          col_q;
  logic [NCells-1:0]   fired;

  logic                in_range;
  logic [5:0]          idx;
  logic [NCells-1:0]   cell_mask;
  logic                is_ship;
  logic                is_fired;

  // Decode the latched coordinate into a one-hot cell mask. The mask is only meaningful when
  // the coordinate is in range; using a mask avoids out-of-range bit selects on the board.
  always_comb begin
    in_range  = (32'(row_q) < ROWS) && (32'(col_q) < COLS);
    idx       = 6'(row_q) * 6'(COLS) + 6'(col_q);
    cell_mask = NCells'(64'd1 << idx);
    is_ship   = |(board_out & cell_mask);
    is_fired  = |(fired & cell_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      fired        <= '0;
      board_out    <= '0;
      shots_left   <= '0;
      shot_ready   <= 1'b0;
      result_valid <= 1'b0;
      result_code  <= 2'b00;
      game_over    <= 1'b0;
      player_won   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        StIdle, StDone: begin
          if (load_valid) begin
            board_out  <= board_in;
            fired      <= '0;
            shots_left <= LimitEn ? 5'(MAX_SHOTS) : 5'd0;
            if (board_in == '0) begin
              // An empty board is an immediate win.
              state      <= StDone;
              shot_ready <= 1'b0;
              game_over  <= 1'b1;
              player_won <= 1'b1;
            end else begin
              state      <= StArmed;
              shot_ready <= 1'b1;
              game_over  <= 1'b0;
              player_won <= 1'b0;
            end
          end
        end

        // shot_ready is high throughout this state, so shot_valid alone completes the handshake.
        // A simultaneous load_valid is deliberately ignored.
        StArmed: begin
          if (shot_valid) begin
            row_q      <= shot_row;
            col_q      <= shot_col;
            shot_ready <= 1'b0;
            state      <= StResolve;
          end
        end

        StResolve: begin
          result_valid <= 1'b1;
          state        <= StReport;
          if (!in_range) begin
            result_code <= 2'b11;
          end else if (is_fired) begin
            result_code <= 2'b10;
          end else begin
            fired <= fired | cell_mask;
            if (is_ship) begin
              result_code <= 2'b01;
              board_out   <= board_out & ~cell_mask;
            end else begin
              result_code <= 2'b00;
            end
            if (LimitEn && shots_left != 5'd0) begin
              shots_left <= shots_left - 5'd1;
            end
          end
        end

        // Clearing the board wins even if the same shot exhausted the budget.
        StReport: begin
          if (board_out == '0) begin
            state      <= StDone;
            game_over  <= 1'b1;
            player_won <= 1'b1;
          end else if (LimitEn && shots_left == 5'd0) begin
            state      <= StDone;
            game_over  <= 1'b1;
            player_won <= 1'b0;
          end else begin
            state      <= StArmed;
            shot_ready <= 1'b1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_resolver.sv
module tb_shot_resolver;

`ifdef SHOT_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [24:0] board_in;
  logic        shot_valid;
  logic        shot_ready;
  logic [2:0]  shot_row;
  logic [2:0]  shot_col;
  logic        result_valid;
  logic [1:0]  result_code;
  logic [24:0] board_out;
  logic [4:0]  shots_left;
  logic        game_over;
  logic        player_won;

  int n_checks = 0;
  int n_fail   = 0;

  shot_resolver #(.ROWS(5), .COLS(5), .MAX_SHOTS(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .board_in     (board_in),
    .shot_valid   (shot_valid),
    .shot_ready   (shot_ready),
    .shot_row     (shot_row),
    .shot_col     (shot_col),
    .result_valid (result_valid),
    .result_code  (result_code),
    .board_out    (board_out),
    .shots_left   (shots_left),
    .game_over    (game_over),
    .player_won   (player_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected budget after k shots consumed.
  function automatic logic [31:0] exp_shots(input int k);
    return LIM ? 32'(15 - k) : 32'd0;
  endfunction

  // One full shot transaction: handshake, RESOLVE, REPORT, then the state after REPORT.
  task automatic fire(input logic [2:0] r, input logic [2:0] c, input logic [1:0] code,
                      input logic [24:0] brd, input logic [31:0] sl, input logic rdy);
    shot_row   = r;
    shot_col   = c;
    shot_valid = 1'b1;
    step();
    shot_valid = 1'b0;
    chk("resolve_ready", 32'(shot_ready), 32'd0);
    chk("resolve_rv", 32'(result_valid), 32'd0);
    step();
    chk("report_rv", 32'(result_valid), 32'd1);
    chk("report_code", 32'(result_code), 32'(code));
    chk("report_board", 32'(board_out), 32'(brd));
    chk("report_shots", 32'(shots_left), sl);
    step();
    chk("after_rv", 32'(result_valid), 32'd0);
    chk("after_ready", 32'(shot_ready), 32'(rdy));
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    board_in   = '0;
    shot_valid = 1'b0;
    shot_row   = '0;
    shot_col   = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 32'(shot_ready), 32'd0);
    chk("rst_board", 32'(board_out), 32'd0);
    chk("rst_shots", 32'(shots_left), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_won", 32'(player_won), 32'd0);

    // Board with ships at (0,0), (0,1), (4,4).
    board_in   = 25'h100_0003;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("load_ready", 32'(shot_ready), 32'd1);
    chk("load_board", 32'(board_out), 32'h100_0003);
    chk("load_shots", 32'(shots_left), exp_shots(0));

    // 1) hit (0,0)
    fire(3'd0, 3'd0, 2'b01, 25'h100_0002, exp_shots(1), 1'b1);
    // 2) miss then repeat on (2,2)
    fire(3'd2, 3'd2, 2'b00, 25'h100_0002, exp_shots(2), 1'b1);
    fire(3'd2, 3'd2, 2'b10, 25'h100_0002, exp_shots(2), 1'b1);
    // 3) invalid coordinates
    fire(3'd5, 3'd3, 2'b11, 25'h100_0002, exp_shots(2), 1'b1);
    fire(3'd7, 3'd7, 2'b11, 25'h100_0002, exp_shots(2), 1'b1);
    // 4) sink the rest
    fire(3'd0, 3'd1, 2'b01, 25'h100_0000, exp_shots(3), 1'b1);
    fire(3'd4, 3'd4, 2'b01, 25'h000_0000, exp_shots(4), 1'b0);
    chk("win_over", 32'(game_over), 32'd1);
    chk("win_won", 32'(player_won), 32'd1);
    chk("win_board", 32'(board_out), 32'd0);
    shot_row   = 3'd1;
    shot_col   = 3'd1;
    shot_valid = 1'b1;
    step();
    step();
    shot_valid = 1'b0;
    chk("done_ready", 32'(shot_ready), 32'd0);
    chk("done_rv", 32'(result_valid), 32'd0);
    chk("done_over", 32'(game_over), 32'd1);

    // 5) reload from DONE with one ship at (4,4), then 15 misses on distinct cells
    board_in   = 25'h100_0000;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("reload_ready", 32'(shot_ready), 32'd1);
    chk("reload_over", 32'(game_over), 32'd0);
    chk("reload_shots", 32'(shots_left), exp_shots(0));
    for (int i = 0; i < 15; i++) begin
      fire(3'(i / 5), 3'(i % 5), 2'b00, 25'h100_0000, exp_shots(i + 1), (i < 14) || !LIM);
    end
    chk("budget_over", 32'(game_over), 32'(LIM));
    chk("budget_won", 32'(player_won), 32'd0);
    chk("budget_shots", 32'(shots_left), 32'd0);

    // 6) reset, reload, simultaneous load+shot, then reset during RESOLVE
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_board", 32'(board_out), 32'd0);
    chk("rst2_over", 32'(game_over), 32'd0);
    board_in   = 25'h100_0000;
    load_valid = 1'b1;
    step();
    chk("load2_ready", 32'(shot_ready), 32'd1);
    board_in = 25'h1FF_FFFF;  // load_valid still high alongside the shot; must be ignored
    fire(3'd0, 3'd0, 2'b00, 25'h100_0000, exp_shots(1), 1'b1);
    load_valid = 1'b0;
    chk("noload_board", 32'(board_out), 32'h100_0000);

    shot_row   = 3'd1;
    shot_col   = 3'd1;
    shot_valid = 1'b1;
    step();
    shot_valid = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_rv", 32'(result_valid), 32'd0);
    chk("abort_ready", 32'(shot_ready), 32'd0);
    chk("abort_board", 32'(board_out), 32'd0);
    chk("abort_shots", 32'(shots_left), 32'd0);
    chk("abort_over", 32'(game_over), 32'd0);
    step();
    chk("abort_rv2", 32'(result_valid), 32'd0);

    board_in   = '0;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("empty_over", 32'(game_over), 32'd1);
    chk("empty_won", 32'(player_won), 32'd1);
    chk("empty_ready", 32'(shot_ready), 32'd0);
    chk("empty_board", 32'(board_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
